// File: rtl/vram_pkg.sv
// Shared constants for the VRAM plot arbiter: resolution-derived geometry,
// colour width helper and controller state encoding.
package vram_pkg;

    typedef logic [55:0] res_t;

    localparam res_t RES_320X240 = "320x240";
    localparam res_t RES_160X120 = "160x120";

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    function automatic int unsigned res_w(input res_t r);
        return (r == RES_160X120) ? 32'd160 : 32'd320;
    endfunction

    function automatic int unsigned res_h(input res_t r);
        return (r == RES_160X120) ? 32'd120 : 32'd240;
    endfunction

    function automatic int unsigned res_xw(input res_t r);
        return (r == RES_160X120) ? 32'd8 : 32'd9;
    endfunction

    function automatic int unsigned res_yw(input res_t r);
        return (r == RES_160X120) ? 32'd7 : 32'd8;
    endfunction

    function automatic int unsigned colour_w(input int unsigned bpc);
        return 32'd3 * bpc;
    endfunction

endpackage

// File: rtl/vram_plot_arbiter_if.sv
// Request, clear-control and video-memory plot signals of the plot arbiter.
// master = drawing engines / memory side, slave = the arbiter.
interface vram_plot_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XW      = 9,
    parameter int unsigned YW      = 8,
    parameter int unsigned CW      = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*XW-1:0] req_x;
    logic [NUM_REQ*YW-1:0] req_y;
    logic [NUM_REQ*CW-1:0] req_colour;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  clear_start;
    logic [CW-1:0]         clear_colour;
    logic                  clear_busy;
    logic                  clear_done;
    logic [XW-1:0]         plot_x;
    logic [YW-1:0]         plot_y;
    logic [CW-1:0]         plot_colour;
    logic                  plot;
    logic                  drop_pulse;

    modport master (
        output req_valid, req_x, req_y, req_colour, clear_start, clear_colour,
        input  req_ready, clear_busy, clear_done, plot_x, plot_y, plot_colour,
               plot, drop_pulse
    );

    modport slave (
        input  req_valid, req_x, req_y, req_colour, clear_start, clear_colour,
        output req_ready, clear_busy, clear_done, plot_x, plot_y, plot_colour,
               plot, drop_pulse
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned k;
            k = (32'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[k]) begin
                o_grant[k] = 1'b1;
                o_idx      = PW'(k);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_plot_arbiter.sv
// Shares the video-memory plot port between NUM_REQ drawing requesters
// (round-robin, valid/ready) and runs a full-screen clear sequencer.
module vram_plot_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned NUM_REQ                 = 4,
    parameter res_t        RESOLUTION              = "320x240",
    parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1
) (
    input  logic               clock,
    input  logic               resetn,
    vram_plot_arbiter_if.slave bus
);

    localparam int unsigned W  = res_w(RESOLUTION);
    localparam int unsigned H  = res_h(RESOLUTION);
    localparam int unsigned XW = res_xw(RESOLUTION);
    localparam int unsigned YW = res_yw(RESOLUTION);
    localparam int unsigned CW = colour_w(BITS_PER_COLOUR_CHANNEL);
    localparam int unsigned PW = $clog2(NUM_REQ);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [XW-1:0] r_cx, r_px, w_px_nxt;
    logic [YW-1:0] r_cy, r_py, w_py_nxt;
    logic [CW-1:0] r_ccol, r_pc, w_pc_nxt;
    logic          r_cfin;
    logic          r_plot, w_plot_nxt;
    logic          r_drop, w_drop_nxt;
    logic          r_done, w_done_nxt;
    logic          w_clr_go;

    logic [NUM_REQ-1:0] w_req, w_grant;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic [XW-1:0]      w_sel_x;
    logic [YW-1:0]      w_sel_y;
    logic [CW-1:0]      w_sel_c;
    logic               w_in_range;

    // Grants only in IDLE; a clear request or reset suppresses all ready.
    assign w_req = (resetn && (r_state == ST_IDLE) && !bus.clear_start) ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .PW     (PW)
    ) u_rr (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_sel_x    = bus.req_x[w_idx*XW +: XW];
    assign w_sel_y    = bus.req_y[w_idx*YW +: YW];
    assign w_sel_c    = bus.req_colour[w_idx*CW +: CW];
    assign w_in_range = (w_sel_x < XW'(W)) && (w_sel_y < YW'(H));

    always_comb begin
        w_state_nxt = r_state;
        w_plot_nxt  = 1'b0;
        w_px_nxt    = '0;
        w_py_nxt    = '0;
        w_pc_nxt    = '0;
        w_drop_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_clr_go    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_go    = 1'b1;
                end else if (w_any) begin
                    if (w_in_range) begin
                        w_plot_nxt = 1'b1;
                        w_px_nxt   = w_sel_x;
                        w_py_nxt   = w_sel_y;
                        w_pc_nxt   = w_sel_c;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                // r_cfin: last dot already issued; this cycle shows it on the port.
                if (r_cfin) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_plot_nxt = 1'b1;
                    w_px_nxt   = r_cx;
                    w_py_nxt   = r_cy;
                    w_pc_nxt   = r_ccol;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_ccol  <= '0;
            r_cfin  <= 1'b0;
            r_plot  <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_pc    <= '0;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_plot  <= w_plot_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_done  <= w_done_nxt;
            if (w_any) begin
                r_ptr <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            end
            if (w_clr_go) begin
                r_cx   <= '0;
                r_cy   <= '0;
                r_cfin <= 1'b0;
                r_ccol <= bus.clear_colour;
            end else if ((r_state == ST_CLEAR) && !r_cfin) begin
                if (r_cx == XW'(W - 1)) begin
                    r_cx <= '0;
                    if (r_cy == YW'(H - 1)) begin
                        r_cy   <= '0;
                        r_cfin <= 1'b1;
                    end else begin
                        r_cy <= r_cy + 1'b1;
                    end
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.plot        = r_plot;
    assign bus.plot_x      = r_px;
    assign bus.plot_y      = r_py;
    assign bus.plot_colour = r_pc;
    assign bus.drop_pulse  = r_drop;
    assign bus.clear_done  = r_done;
    assign bus.clear_busy  = (r_state == ST_CLEAR);

endmodule
